// File: rtl/restoring_divider.sv
// ============================================================================
// Module      : restoring_divider
// Description : 32-bit signed divider, one restoring step per cycle, with a
//               single-cycle completion pulse and divide-by-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module restoring_divider (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [5:0] C_LAST_STEP = 6'd31;

  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_div;
  logic        r_sign;
  logic [31:0] r_result;
  logic        r_exc;

  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [32:0] w_rem_sh;
  logic [32:0] w_trial;
  logic [31:0] w_rem_next;
  logic [31:0] w_quo_next;
  logic [31:0] w_quo_signed;

  // Magnitude of -2^31 wraps to 0x80000000, which is the correct unsigned value.
  assign w_mag_a = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
  assign w_mag_b = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;

  // Remainder stays below the divisor (<= 2^31), so the shifted value never
  // reaches bit 32 and the trial's top bit is a clean borrow indicator.
  assign w_rem_sh = {r_rem, r_quo[31]};
  assign w_trial  = w_rem_sh - {1'b0, r_div};

  always_comb begin
    w_rem_next = w_rem_sh[31:0];
    w_quo_next = {r_quo[30:0], 1'b0};
    if (!w_trial[32]) begin
      w_rem_next = w_trial[31:0];
      w_quo_next = {r_quo[30:0], 1'b1};
    end
  end

  assign w_quo_signed = r_sign ? (32'd0 - w_quo_next) : w_quo_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 6'd0;
      r_rem    <= 32'd0;
      r_quo    <= 32'd0;
      r_div    <= 32'd0;
      r_sign   <= 1'b0;
      r_result <= 32'd0;
      r_exc    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ctrl_DIV) begin
            r_div  <= w_mag_b;
            r_quo  <= w_mag_a;
            r_rem  <= 32'd0;
            r_sign <= data_operandA[31] ^ data_operandB[31];
            r_cnt  <= 6'd0;
            if (w_mag_b == 32'd0) begin
              r_state  <= S_DONE;
              r_result <= 32'd0;
              r_exc    <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == C_LAST_STEP) begin
            r_state  <= S_DONE;
            r_result <= w_quo_signed;
            r_exc    <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = (r_state == S_DONE);
  assign busy           = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_restoring_divider.sv
// ============================================================================
// Module      : tb_restoring_divider
// Description : Directed and random checks of restoring_divider against an
//               arithmetic reference quotient.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_restoring_divider;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int          n_pass;
  int          n_total;
  logic [31:0] exp_prev;
  logic        exc_prev;

  restoring_divider dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Signed quotient truncated toward zero, 64-bit so -2^31/-1 wraps naturally.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint q;
    q = longint'($signed(a)) / longint'($signed(b));
    return q[31:0];
  endfunction

  task automatic step;
    @(posedge clock);
    @(negedge clock);
  endtask

  // Caller is positioned just after a falling edge; the next rising edge is E0.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] er;
    logic        ee;
    int          lat_exp;
    int          lat;
    bit          hold_ok;
    bit          busy_ok;
    ee      = (b == 32'd0);
    er      = ee ? 32'd0 : ref_div(a, b);
    lat_exp = ee ? 0 : 32;
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    step();
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    lat     = 0;
    hold_ok = 1'b1;
    busy_ok = 1'b1;
    while (data_resultRDY !== 1'b1 && lat < 40) begin
      if (data_result !== exp_prev || data_exception !== exc_prev) hold_ok = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      step();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(lat_exp));
    chk({tag, " result"}, data_result, er);
    chk({tag, " exception"}, {31'd0, data_exception}, {31'd0, ee});
    chk({tag, " busy_done"}, {31'd0, busy}, 32'd1);
    if (!ee) begin
      chk({tag, " hold_during_run"}, {31'd0, hold_ok}, 32'd1);
      chk({tag, " busy_run"}, {31'd0, busy_ok}, 32'd1);
    end
    step();
    chk({tag, " rdy_after"}, {31'd0, data_resultRDY}, 32'd0);
    chk({tag, " busy_after"}, {31'd0, busy}, 32'd0);
    exp_prev = er;
    exc_prev = ee;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] res_at_rdy;
    int          rdy_cnt;
    int          k_rdy;
    bit          saw_rdy;

    n_pass        = 0;
    n_total       = 0;
    exp_prev      = 32'd0;
    exc_prev      = 1'b0;
    reset         = 1'b1;
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    repeat (3) step();
    chk("reset result", data_result, 32'd0);
    chk("reset exception", {31'd0, data_exception}, 32'd0);
    chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    // First edge after reset release must accept.
    run_op(32'd100, 32'd7, "100/7");
    run_op(32'hFFFF_FF9C, 32'd7, "-100/7");
    run_op(32'd100, 32'hFFFF_FFF9, "100/-7");
    run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, "-100/-7");
    run_op(32'd5, 32'd0, "5/0");
    run_op(32'd9, 32'd3, "9/3");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, "min/-1");
    run_op(32'h8000_0000, 32'd1, "min/1");
    run_op(32'd7, 32'd100, "7/100");
    run_op(32'h7FFF_FFFF, 32'h8000_0000, "max/min");

    // Abort 1000/10 with reset at E10.
    data_operandA = 32'd1000;
    data_operandB = 32'd10;
    ctrl_DIV      = 1'b1;
    step();
    ctrl_DIV = 1'b0;
    saw_rdy  = 1'b0;
    repeat (9) begin
      step();
      if (data_resultRDY === 1'b1) saw_rdy = 1'b1;
    end
    reset = 1'b1;
    step();
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("abort result", data_result, 32'd0);
    chk("abort no_pulse_before", {31'd0, saw_rdy}, 32'd0);
    reset    = 1'b0;
    exp_prev = 32'd0;
    exc_prev = 1'b0;
    run_op(32'd6, 32'd3, "6/3 after abort");

    // Start requests while busy must be ignored.
    data_operandA = 32'd50;
    data_operandB = 32'd5;
    ctrl_DIV      = 1'b1;
    step();
    rdy_cnt    = 0;
    k_rdy      = -1;
    res_at_rdy = 32'hDEAD_BEEF;
    for (int k = 1; k <= 33; k++) begin
      if (k == 5 || k == 33) begin
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd8;
        data_operandB = 32'd2;
      end else begin
        ctrl_DIV = 1'b0;
      end
      step();
      if (data_resultRDY === 1'b1) begin
        rdy_cnt++;
        k_rdy      = k;
        res_at_rdy = data_result;
      end
    end
    ctrl_DIV = 1'b0;
    chk("repulse rdy_count", 32'(rdy_cnt), 32'd1);
    chk("repulse rdy_edge", 32'(k_rdy), 32'd32);
    chk("repulse result", res_at_rdy, 32'd10);
    chk("repulse idle_e33", {31'd0, busy}, 32'd0);
    step();
    chk("repulse idle_e34", {31'd0, busy}, 32'd0);
    chk("repulse hold", data_result, 32'd10);
    exp_prev = 32'd10;
    exc_prev = 1'b0;

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      case (i % 4)
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(1, 300));
        2:       rb = 32'd0 - 32'($urandom_range(1, 300));
        default: rb = (i == 7) ? 32'd0 : 32'($urandom_range(0, 65535));
      endcase
      run_op(ra, rb, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL have port: clock  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: data_operandA  in  32  dividend, two's complement.
REQ-004 SHALL have port: data_operandB  in  32  divisor, two's complement.
REQ-005 SHALL have port: ctrl_DIV  in  1  start request; operands sampled on the same edge.
REQ-006 SHALL have port: data_result  out  32  signed quotient, truncated toward zero.
REQ-007 SHALL have port: data_exception  out  1  divide-by-zero flag, valid with data_result.
REQ-008 SHALL have port: data_resultRDY  out  1  one-cycle completion pulse.
REQ-009 SHALL have port: busy  out  1  high while an operation is in flight (RUN or DONE).

Function
REQ-010 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-011 IDLE: ctrl_DIV=1 at edge E0 SHALL latch |A| and |B| as 32-bit unsigned magnitudes, sign = A[31]^B[31], and clear iteration counter.
REQ-012 IDLE start with B != 0 SHALL enter RUN; with B == 0 it SHALL enter DONE directly at E0.
REQ-013 RUN SHALL perform one restoring step per cycle: shift {rem,quo} left 1; trial = rem - |B| (33-bit); if trial >= 0, rem <= trial and quo LSB <= 1, else quo LSB <= 0.
REQ-014 RUN SHALL execute exactly 32 steps (edges E1..E32) via a 6-bit counter, then enter DONE at edge E32.
REQ-015 data_resultRDY SHALL be 1 for exactly the cycle spent in DONE (E32 to E33 normal; E0 to E1 divide-by-zero); FSM SHALL return to IDLE on the next edge.
REQ-016 On DONE entry, data_result SHALL load sign ? -quo : quo (32-bit two's complement, wrap allowed); data_exception SHALL load 0.
REQ-017 Divide-by-zero: data_result SHALL load 0 and data_exception SHALL load 1.
REQ-018 -2^31 / -1 SHALL return 0x80000000 with data_exception=0 (documented wrap).
REQ-019 data_result and data_exception SHALL hold until the next DONE entry; they SHALL NOT change during a subsequent RUN.
REQ-020 ctrl_DIV SHALL be ignored in RUN and DONE; no queuing, and latched operands SHALL NOT change.
REQ-021 Operand inputs SHALL be don't-care except at the accepting edge.
REQ-022 busy SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-023 No remainder output; remainder state is internal only.

Reset
REQ-024 reset=1 at any edge SHALL force IDLE, counter 0, data_result 0, data_exception 0, data_resultRDY 0, busy 0.
REQ-025 reset SHALL take priority over ctrl_DIV on the same edge; an aborted operation SHALL produce no data_resultRDY pulse.
REQ-026 After reset deasserts, a ctrl_DIV on the first following edge SHALL be accepted.

Verification
REQ-027 A=100, B=7, start at E0 -> data_resultRDY high only during E32..E33, data_result=14, data_exception=0, busy high E0..E33.
REQ-028 A=-100 (0xFFFFFF9C), B=7 -> data_result=0xFFFFFFF2 (-14); A=100, B=-7 -> 0xFFFFFFF2; A=-100, B=-7 -> 14.
REQ-029 A=5, B=0 -> data_resultRDY during E0..E1, data_result=0, data_exception=1; next op 9/3 -> 3 with data_exception=0.
REQ-030 A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, data_exception=0; A=0x80000000, B=1 -> 0x80000000.
REQ-031 Start 1000/10, reset=1 at E10 -> busy=0 from E10, no RDY pulse, data_result=0; then 6/3 -> 2 at E32 of the new op.
REQ-032 Start 50/5, re-pulse ctrl_DIV at E5 with 8/2 and at the DONE cycle -> single RDY pulse, data_result=10, FSM back in IDLE at E33.
